// File: rtl/cpu_alu_core_pkg.sv
// Shared CPU definitions: ALU opcode encoding and shifter mode, reused by the
// decoder/control unit and the execute-stage ALU.
package cpu_alu_core_pkg;

    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_opcode_t;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_mode_t;

endpackage

// File: rtl/cpu_alu_core_if.sv
// Operand/result bundle between the execute stage and the ALU.
// Optional CPU_ALU_EXT_FLAGS_EN adds the n/c/v flag signals.
interface cpu_alu_core_if
    import cpu_alu_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic [ALU_OP_W-1:0]   op_sel;
    logic                  z_flag;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [DATA_WIDTH-1:0] alu_out_q;
    logic                  z_flag_q;
`ifdef CPU_ALU_EXT_FLAGS_EN
    logic                  n_flag;
    logic                  c_flag;
    logic                  v_flag;

    modport master (
        output in_a, in_b, op_sel,
        input  z_flag, alu_out, alu_out_q, z_flag_q, n_flag, c_flag, v_flag
    );
    modport slave (
        input  in_a, in_b, op_sel,
        output z_flag, alu_out, alu_out_q, z_flag_q, n_flag, c_flag, v_flag
    );
`else
    modport master (
        output in_a, in_b, op_sel,
        input  z_flag, alu_out, alu_out_q, z_flag_q
    );
    modport slave (
        input  in_a, in_b, op_sel,
        output z_flag, alu_out, alu_out_q, z_flag_q
    );
`endif
endinterface

// File: rtl/cpu_alu_shifter.sv
// Logarithmic barrel shifter for SLL/SRL/SRA; left shifts reuse the
// right-shift stages by bit-reversing the data on the way in and out.
module cpu_alu_shifter
    import cpu_alu_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic [$clog2(DATA_WIDTH)-1:0] sh_i,
    input  shift_mode_t                   mode_i,
    output logic [DATA_WIDTH-1:0]         data_o
);
    localparam int unsigned SH_W = $clog2(DATA_WIDTH);

    logic                  left;
    logic                  fill;
    logic [DATA_WIDTH-1:0] ones;
    logic [DATA_WIDTH-1:0] cur;

    assign left = (mode_i == SH_SLL);
    assign fill = (mode_i == SH_SRA) & data_i[DATA_WIDTH-1];
    assign ones = '1;

    always_comb begin
        cur    = '0;
        data_o = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            cur[i] = left ? data_i[DATA_WIDTH-1-i] : data_i[i];
        end
        // Stage i shifts by 2**i; fill mask covers the vacated top bits.
        for (int unsigned i = 0; i < SH_W; i++) begin
            if (sh_i[i]) begin
                cur = (cur >> (32'd1 << i)) | (fill ? ~(ones >> (32'd1 << i)) : '0);
            end
        end
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            data_o[i] = left ? cur[DATA_WIDTH-1-i] : cur[i];
        end
    end

endmodule

// File: rtl/cpu_alu_core.sv
// RV32I execute-stage ALU: combinational result/zero flag plus a one-cycle
// registered copy. Define CPU_ALU_EXT_FLAGS_EN for n/c/v flag outputs.
module cpu_alu_core
    import cpu_alu_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    cpu_alu_core_if.slave bus
);
    localparam int unsigned SH_W = $clog2(DATA_WIDTH);
    localparam int unsigned MSB  = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] b_op;
    logic [DATA_WIDTH:0]   addsub;
    logic                  use_sub;
    logic                  slt_bit;
    logic                  sltu_bit;
    shift_mode_t           sh_mode;
    logic [DATA_WIDTH-1:0] shift_res;
    logic [DATA_WIDTH-1:0] result_d;
    logic                  zero_d;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;

    assign a = bus.in_a;
    assign b = bus.in_b;

    // Single a + ~b + 1 path serves ADD, SUB and both compares.
    assign use_sub  = (bus.op_sel != ALU_ADD);
    assign b_op     = use_sub ? ~b : b;
    assign addsub   = {1'b0, a} + {1'b0, b_op} + {{DATA_WIDTH{1'b0}}, use_sub};
    assign slt_bit  = (a[MSB] ^ b[MSB]) ? a[MSB] : addsub[MSB];
    assign sltu_bit = ~addsub[DATA_WIDTH];

    always_comb begin
        sh_mode = SH_SLL;
        case (bus.op_sel)
            ALU_SRL: sh_mode = SH_SRL;
            ALU_SRA: sh_mode = SH_SRA;
            default: sh_mode = SH_SLL;
        endcase
    end

    cpu_alu_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .data_i (a),
        .sh_i   (b[SH_W-1:0]),
        .mode_i (sh_mode),
        .data_o (shift_res)
    );

    always_comb begin
        result_d = '0;
        case (bus.op_sel)
            ALU_ADD,
            ALU_SUB:  result_d = addsub[DATA_WIDTH-1:0];
            ALU_AND:  result_d = a & b;
            ALU_OR:   result_d = a | b;
            ALU_XOR:  result_d = a ^ b;
            ALU_SLT:  result_d = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
            ALU_SLTU: result_d = {{(DATA_WIDTH-1){1'b0}}, sltu_bit};
            ALU_SLL,
            ALU_SRA,
            ALU_SRL:  result_d = shift_res;
            default:  result_d = '0;
        endcase
    end

    assign zero_d = (result_d == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.alu_out   = result_d;
    assign bus.z_flag    = zero_d;
    assign bus.alu_out_q = result_q;
    assign bus.z_flag_q  = zero_q;

`ifdef CPU_ALU_EXT_FLAGS_EN
    logic is_arith;

    assign is_arith   = (bus.op_sel == ALU_ADD) || (bus.op_sel == ALU_SUB);
    assign bus.n_flag = result_d[MSB];
    // SUB carry is NOT borrow, i.e. 1 when a >= b unsigned.
    assign bus.c_flag = is_arith & addsub[DATA_WIDTH];
    assign bus.v_flag = is_arith & (a[MSB] == b_op[MSB]) & (addsub[MSB] != a[MSB]);
`endif

endmodule

// File: tb/tb_cpu_alu_core.sv
// Self-checking bench for cpu_alu_core: directed vector table, registered-path
// and reset sequences, and random vectors against an independent model.
module tb_cpu_alu_core;
    import cpu_alu_core_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    cpu_alu_core_if #(.DATA_WIDTH(32)) bus ();

    cpu_alu_core #(
        .DATA_WIDTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return a << sh;
            4'd7:    return $unsigned($signed(a) >>> sh);
            4'd8:    return a >> sh;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op_sel = op;
        bus.in_a   = a;
        bus.in_b   = b;
    endtask

    task automatic push_exp(input logic [31:0] out, input logic z);
        exp_t e;
        e.out = out;
        e.z   = z;
        sb.push_back(e);
    endtask

    task automatic check_pop(input string name, input logic [31:0] act, input logic act_z);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            e = sb.pop_front();
            check(name, act, e.out);
            check({name, "_z"}, {31'd0, act_z}, {31'd0, e.z});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        tbl.push_back('{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1});
        tbl.push_back('{ALU_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0});
        tbl.push_back('{ALU_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0});
        tbl.push_back('{ALU_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1});
        tbl.push_back('{ALU_SLT,  32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b1});
        tbl.push_back('{ALU_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0});
        tbl.push_back('{ALU_SRL,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0});
        tbl.push_back('{ALU_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0});
        tbl.push_back('{4'hC,     32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
        tbl.push_back('{ALU_AND,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1});
        tbl.push_back('{ALU_OR,   32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0});
        tbl.push_back('{ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0});
        tbl.push_back('{ALU_SLL,  32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0});
        tbl.push_back('{ALU_SRA,  32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 1'b1});
        tbl.push_back('{ALU_SRA,  32'hFFFF_FFFF, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0});
        tbl.push_back('{ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        tbl.push_back('{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
        tbl.push_back('{ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
        tbl.push_back('{4'hF,     32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1});
        tbl.push_back('{ALU_SUB,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1});
        tbl.push_back('{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0});
        tbl.push_back('{ALU_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1});
        tbl.push_back('{ALU_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0});
        tbl.push_back('{4'hA,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});

        // Reset state
        apply(ALU_ADD, 32'd0, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("rst_out_q", bus.alu_out_q, 32'h0);
        check("rst_z_q", {31'd0, bus.z_flag_q}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed combinational table
        foreach (tbl[i]) begin
            apply(tbl[i].op, tbl[i].a, tbl[i].b);
            push_exp(tbl[i].out, tbl[i].z);
            #1;
            check_pop($sformatf("tbl%0d", i), bus.alu_out, bus.z_flag);
        end

        // Registered path and asynchronous reset between edges
        @(negedge clk);
        apply(ALU_XOR, 32'h0000_00A5, 32'h0000_005A);
        push_exp(32'h0000_00FF, 1'b0);
        @(posedge clk);
        #1;
        check_pop("xor_q", bus.alu_out_q, bus.z_flag_q);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_q", bus.alu_out_q, 32'h0);
        check("async_rst_z_q", {31'd0, bus.z_flag_q}, 32'h0);
        check("rst_comb_out", bus.alu_out, 32'h0000_00FF);
        @(posedge clk);
        #1;
        check("rst_held_out_q", bus.alu_out_q, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apply(ALU_ADD, 32'd2, 32'd3);
        push_exp(32'd5, 1'b0);
        #1;
        check("pre_edge_out_q", bus.alu_out_q, 32'h0);
        @(posedge clk);
        #1;
        check_pop("first_after_rst_q", bus.alu_out_q, bus.z_flag_q);

        // One-cycle latency: old value holds until the edge
        @(negedge clk);
        apply(ALU_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        push_exp(32'h0, 1'b1);
        #1;
        check("latency_hold_q", bus.alu_out_q, 32'd5);
        @(posedge clk);
        #1;
        check_pop("and_q", bus.alu_out_q, bus.z_flag_q);

        // Random vectors, combinational then registered
        for (int unsigned n = 0; n < 1000; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] r;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
            r  = ref_alu(op, a, b);
            @(negedge clk);
            apply(op, a, b);
            push_exp(r, r == 32'd0);
            #1;
            check_pop($sformatf("rnd%0d_op%0d", n, op), bus.alu_out, bus.z_flag);
            push_exp(r, r == 32'd0);
            @(posedge clk);
            #1;
            check_pop($sformatf("rnd%0d_q", n), bus.alu_out_q, bus.z_flag_q);
        end

`ifdef CPU_ALU_EXT_FLAGS_EN
        @(negedge clk);
        apply(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        #1;
        check("ext_add_nvc", {29'd0, bus.n_flag, bus.v_flag, bus.c_flag}, 32'b110);
        apply(ALU_SUB, 32'd5, 32'd3);
        #1;
        check("ext_sub_ge_nvc", {29'd0, bus.n_flag, bus.v_flag, bus.c_flag}, 32'b001);
        apply(ALU_SUB, 32'd3, 32'd5);
        #1;
        check("ext_sub_lt_nvc", {29'd0, bus.n_flag, bus.v_flag, bus.c_flag}, 32'b100);
        apply(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        #1;
        check("ext_add_carry_nvc", {29'd0, bus.n_flag, bus.v_flag, bus.c_flag}, 32'b001);
        apply(ALU_OR, 32'h8000_0000, 32'h0000_0000);
        #1;
        check("ext_or_nvc", {29'd0, bus.n_flag, bus.v_flag, bus.c_flag}, 32'b100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
